div_iter_core: RTL

DIV_ITER_CORE -- requirements
Module: div_iter_core

---
 rtl/div_iter_core_if.sv | 27 ++
 rtl/div_iter_core.sv | 99 +++++++++
 2 files changed

// File: rtl/div_iter_core_if.sv
// Handshake and data bundle for the iterative divider core.
// master drives requests and operands; slave is the divider itself.
interface div_iter_core_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [1:0]      op_div_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] quot_o;
  logic [XLEN-1:0] rem_o;
  logic            dividend_neg_o;
  logic            divisor_neg_o;
  logic [1:0]      op_div_o;

  modport master (
    output start_i, dividend_i, divisor_i, op_div_i,
    input  busy_o, done_o, quot_o, rem_o, dividend_neg_o, divisor_neg_o, op_div_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i, op_div_i,
    output busy_o, done_o, quot_o, rem_o, dividend_neg_o, divisor_neg_o, op_div_o
  );
endinterface

// File: rtl/div_iter_core.sv
// Radix-2 restoring divider on operand magnitudes: one quotient bit per clock,
// signs and op code are passed on for a downstream sign-correction stage.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  div_iter_core_if.slave  div
);
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] quot_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic            dividend_neg_reg;
  logic            divisor_neg_reg;
  logic [1:0]      op_reg;

  // Operand 0 is the dividend, operand 1 the divisor.
  logic [XLEN-1:0] opnd [2];
  logic [XLEN-1:0] mag  [2];
  logic [1:0]      neg;

  assign opnd[0] = div.dividend_i;
  assign opnd[1] = div.divisor_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
      // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
      assign neg[gi] = ~div.op_div_i[0] & opnd[gi][XLEN-1];
      assign mag[gi] = neg[gi] ? (~opnd[gi] + 1'b1) : opnd[gi];
    end
  endgenerate

  // Trial subtraction is one bit wider than the operands so the shifted-out remainder bit is kept.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  assign shifted = {rem_reg, quot_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_reg};
  assign fits    = (shifted >= {1'b0, dvs_reg});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      quot_reg         <= '0;
      rem_reg          <= '0;
      dvs_reg          <= '0;
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
      op_reg           <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (div.start_i) begin
            op_reg           <= div.op_div_i;
            dividend_neg_reg <= neg[0];
            divisor_neg_reg  <= neg[1];
            quot_reg         <= mag[0];
            dvs_reg          <= mag[1];
            rem_reg          <= '0;
            count_reg        <= '0;
            state_reg        <= RUN;
          end
        end
        RUN: begin
          rem_reg   <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          quot_reg  <= {quot_reg[XLEN-2:0], fits};
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(XLEN - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign div.busy_o         = (state_reg != IDLE);
  assign div.done_o         = (state_reg == DONE);
  assign div.quot_o         = quot_reg;
  assign div.rem_o          = rem_reg;
  assign div.dividend_neg_o = dividend_neg_reg;
  assign div.divisor_neg_o  = divisor_neg_reg;
  assign div.op_div_o       = op_reg;
endmodule
